// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - time-multiplexed digit scan controller with frame-synchronous double buffering
module display_scan_ctrl #(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     blank_i,
    output logic [3:0]            digit_o,
    output logic                  en_o,
    output logic [DIGITS-1:0]     sel_o,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_shadow_data;
    logic [DIGITS-1:0]     r_shadow_blank;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_blank;
    logic                  r_bnd_d;

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_guard_ok;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic [DIGITS-1:0]     w_sel;

    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_boundary = w_tick && (r_idx == IDX_MAX);

    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard_ok = 1'b1;
        end else begin : g_guard
            assign w_guard_ok = (r_presc >= PW'(GUARD));
        end
    endgenerate

    always_comb begin
        w_digit = 4'h0;
        w_blank = 1'b1;
        w_sel   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_digit  = r_shadow_data[4*k +: 4];
                w_blank  = r_shadow_blank[k];
                w_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_presc        <= '0;
            r_idx          <= '0;
            r_shadow_data  <= '0;
            r_shadow_blank <= '1;
            r_pend_data    <= '0;
            r_pend_blank   <= '0;
            r_bnd_d        <= 1'b0;
            pending_o      <= 1'b0;
            digit_o        <= 4'h0;
            en_o           <= 1'b0;
            sel_o          <= '0;
            frame_o        <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end

            sel_o   <= w_sel;
            digit_o <= w_digit;
            en_o    <= ~w_blank & w_guard_ok;

            // Boundary is delayed twice so frame_o rises together with sel_o on digit 0.
            r_bnd_d <= w_boundary;
            frame_o <= r_bnd_d;

            if (load_i && w_boundary) begin
                r_shadow_data  <= data_i;
                r_shadow_blank <= blank_i;
                pending_o      <= 1'b0;
            end else if (w_boundary && pending_o) begin
                r_shadow_data  <= r_pend_data;
                r_shadow_blank <= r_pend_blank;
                pending_o      <= 1'b0;
            end else if (load_i) begin
                r_pend_data    <= data_i;
                r_pend_blank   <= blank_i;
                pending_o      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl against a cycle-count reference model
module tb_display_scan_ctrl;

    localparam int DIGITS  = 8;
    localparam int CLK_DIV = 4;
    localparam int GUARD   = 1;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic                clk_i = 1'b0;
    logic                rst_n_i = 1'b0;
    logic                load_i = 1'b0;
    logic [4*DIGITS-1:0] data_i = '0;
    logic [DIGITS-1:0]   blank_i = '0;
    logic [3:0]          digit_o;
    logic                en_o;
    logic [DIGITS-1:0]   sel_o;
    logic                frame_o;
    logic                pending_o;

    display_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (load_i),
        .data_i    (data_i),
        .blank_i   (blank_i),
        .digit_o   (digit_o),
        .en_o      (en_o),
        .sel_o     (sel_o),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DIGITS-1:0] sel;
        logic [3:0]        digit;
        logic              en;
        logic              frame;
        logic              pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    // Reference model: position in the scan derives purely from edges counted since reset release.
    initial begin
        logic [4*DIGITS-1:0] sh_d, pd_d;
        logic [DIGITS-1:0]   sh_b, pd_b;
        bit                  pend;
        int                  k, idx, pos;
        exp_t                e;
        sh_d = '0; sh_b = '1; pd_d = '0; pd_b = '0; pend = 0;
        forever begin
            @(posedge clk_i or negedge rst_n_i);
            if (!rst_n_i) begin
                cyc = 0; sh_d = '0; sh_b = '1; pd_d = '0; pd_b = '0; pend = 0;
                exp_q.delete();
            end else begin
                k   = cyc;
                idx = (k / CLK_DIV) % DIGITS;
                pos = k % CLK_DIV;
                e.sel   = DIGITS'(1) << idx;
                e.digit = sh_d[4*idx +: 4];
                e.en    = !sh_b[idx] && (pos >= GUARD);
                e.frame = (k >= FRAME) && (k % FRAME == 0);
                if (k % FRAME == FRAME - 1) begin
                    if (load_i) begin
                        sh_d = data_i; sh_b = blank_i;
                    end else if (pend) begin
                        sh_d = pd_d; sh_b = pd_b;
                    end
                    pend = 0;
                end else if (load_i) begin
                    pd_d = data_i; pd_b = blank_i; pend = 1;
                end
                e.pend = pend;
                exp_q.push_back(e);
                cyc++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel_o",     32'(sel_o),     32'(e.sel));
                check("digit_o",   32'(digit_o),   32'(e.digit));
                check("en_o",      32'(en_o),      32'(e.en));
                check("frame_o",   32'(frame_o),   32'(e.frame));
                check("pending_o", 32'(pending_o), 32'(e.pend));
            end
        end
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2*FRAME; i++) begin
            if (cyc % FRAME == ph) break;
            @(negedge clk_i);
        end
    endtask

    task automatic load(input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] b);
        data_i = d; blank_i = b; load_i = 1'b1;
        @(negedge clk_i);
        load_i = 1'b0; data_i = $urandom; blank_i = DIGITS'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel_o"},     32'(sel_o),     32'h0);
        check({tag, "_digit_o"},   32'(digit_o),   32'h0);
        check({tag, "_en_o"},      32'(en_o),      32'h0);
        check({tag, "_frame_o"},   32'(frame_o),   32'h0);
        check({tag, "_pending_o"}, 32'(pending_o), 32'h0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        run(3);
        check_reset_outputs("rst");
        rst_n_i = 1'b1;
        run(40);

        wait_phase(10);
        load(32'h7654_3210, 8'h00);
        run(70);

        wait_phase(5);
        load(32'h1111_1111, 8'h00);
        wait_phase(20);
        load(32'h2222_2222, 8'h00);
        run(50);

        wait_phase(8);
        load(32'hAAAA_AAAA, 8'h00);
        wait_phase(FRAME - 1);
        load(32'hEEEE_EEEE, 8'h00);
        run(40);

        wait_phase(3);
        load(32'h7654_3210, 8'b1010_0101);
        run(70);

        for (int i = 0; i < 12; i++) begin
            wait_phase($urandom_range(0, FRAME - 1));
            load($urandom, DIGITS'($urandom));
            run($urandom_range(1, 40));
        end

        wait_phase(12);
        load(32'h89AB_CDEF, 8'h00);
        run(2);
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 check_reset_outputs("async_rst");
        run(2);
        rst_n_i = 1'b1;
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
